// File: rtl/rv32i_fetch_unit.sv
// rv32i_fetch_unit: RV32I fetch stage; word fetches over req/gnt+rvalid, PC-tagged prefetch queue to ID.
// Latency: grant in cycle N, response in N+1, instruction valid towards ID in N+2.
// Backpressure: id_ready low fills the queue; requests stop once queued + in-flight words reach FIFO_DEPTH.
// Optional feature macro RV32I_IF_MISALIGN_CHECK_EN: misaligned redirects raise a sticky error and halt fetching.
module rv32i_fetch_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            o_mem_req,
  output logic [XLEN-3:0] o_mem_addr,
  input  logic            i_mem_gnt,
  input  logic            i_mem_rvalid,
  input  logic [31:0]     i_mem_rdata,
  input  logic            i_jump_enable,
  input  logic [XLEN-1:0] i_jump_addr,
  output logic            o_if_valid,
  input  logic            i_id_ready,
  output logic [31:0]     o_iw_out,
  output logic [XLEN-1:0] o_pc_out,
  output logic            o_misalign_err
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int WW = XLEN - 2;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  // PCs are kept as word addresses; the two low bits are always zero.
  logic [WW-1:0] r_pc;
  logic [WW-1:0] r_resp_pc;
  logic [31:0]   r_iw_mem  [FIFO_DEPTH];
  logic [WW-1:0] r_pcw_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;

  logic          w_halt;
  logic          w_credit_ok;
  logic          w_grant;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [CW-1:0] w_out_next;
  logic [WW-1:0] w_target_word;

`ifdef RV32I_IF_MISALIGN_CHECK_EN
  logic r_misalign_err;
  logic w_misalign;

  assign w_misalign = |i_jump_addr[1:0];

  // Sticky misalignment flag: set by a misaligned redirect, cleared by reset or an aligned redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_misalign_err <= 1'b0;
    end else if (i_jump_enable) begin
      r_misalign_err <= w_misalign;
    end
  end

  assign w_halt = r_misalign_err;
`else
  // Low target bits are ignored: redirects always land on the containing word.
  logic w_unused;
  assign w_unused = ^i_jump_addr[1:0];
  assign w_halt   = 1'b0;
`endif

  assign o_misalign_err = w_halt;
  assign w_target_word  = i_jump_addr[XLEN-1:2];

  // Credits: every queued word plus every in-flight word (including ones to be discarded)
  // holds a queue slot, so a response can never arrive at a full queue.
  assign w_credit_ok = ({1'b0, r_count} + {1'b0, r_outstanding}) < DEPTH_C;
  assign o_mem_req   = !reset && !w_halt && w_credit_ok;
  assign o_mem_addr  = r_pc;
  assign w_grant     = o_mem_req & i_mem_gnt;

  assign o_if_valid  = (r_count != '0);
  assign o_iw_out    = o_if_valid ? r_iw_mem[r_rd_ptr] : 32'd0;
  assign o_pc_out    = o_if_valid ? {r_pcw_mem[r_rd_ptr], 2'b00} : '0;

  // A redirect wins over pop and push in the same cycle; its response is dropped.
  assign w_pop      = o_if_valid & i_id_ready & !i_jump_enable;
  assign w_drop     = i_mem_rvalid & (r_discard != '0);
  assign w_push     = i_mem_rvalid & (r_discard == '0) & !i_jump_enable;
  assign w_out_next = r_outstanding + CW'(w_grant) - CW'(i_mem_rvalid);

  // Fetch/response bookkeeping, queue pointers and redirect flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= RESET_PC[XLEN-1:2];
      r_resp_pc     <= RESET_PC[XLEN-1:2];
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (i_jump_enable) begin
        // Everything still in flight after this cycle belongs to the old stream.
        r_pc      <= w_target_word;
        r_resp_pc <= w_target_word;
        r_wr_ptr  <= '0;
        r_rd_ptr  <= '0;
        r_count   <= '0;
        r_discard <= w_out_next;
      end else begin
        if (w_grant) begin
          r_pc <= r_pc + WW'(1);
        end
        if (w_drop) begin
          r_discard <= r_discard - CW'(1);
        end
        if (w_push) begin
          r_resp_pc <= r_resp_pc + WW'(1);
          r_wr_ptr  <= r_wr_ptr + AW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // Queue storage: tag each accepted response word with the PC it was fetched from.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_iw_mem[r_wr_ptr]  <= i_mem_rdata;
      r_pcw_mem[r_wr_ptr] <= r_resp_pc;
    end
  end

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// tb_rv32i_fetch_unit: directed scenarios plus a randomized run against a stream-level model.
// The memory returns a word derived from its address, so every delivered word must match its PC.
module tb_rv32i_fetch_unit;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        o_mem_req;
  logic [29:0] o_mem_addr;
  logic        i_mem_gnt;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        i_jump_enable;
  logic [31:0] i_jump_addr;
  logic        o_if_valid;
  logic        i_id_ready;
  logic [31:0] o_iw_out;
  logic [31:0] o_pc_out;
  logic        o_misalign_err;

  rv32i_fetch_unit #(.XLEN(XLEN), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .i_mem_gnt(i_mem_gnt),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .i_jump_enable(i_jump_enable), .i_jump_addr(i_jump_addr),
    .o_if_valid(o_if_valid), .i_id_ready(i_id_ready),
    .o_iw_out(o_iw_out), .o_pc_out(o_pc_out), .o_misalign_err(o_misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int due; logic [31:0] data; } resp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          ngrants = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          rand_gaps = 0;
  bit          prev_jump = 0;
  bit          m_err = 0;
  logic [31:0] m_fetch = 0;
  logic [31:0] m_exp = 0;
  resp_t       pend[$];
  logic [31:0] dlv[$];

  function automatic logic [31:0] iw_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] first_dlv();
    return (dlv.size() > 0) ? dlv[0] : 32'hDEAD_BEEF;
  endfunction

  task automatic do_reset();
    reset = 1'b1; i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
    i_id_ready = 1'b0; i_jump_enable = 1'b0; i_jump_addr = '0;
    pend.delete();
    m_fetch = 32'h0; m_exp = 32'h0; m_err = 1'b0; prev_jump = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req",  32'(o_mem_req), 32'd0);
    check("rst_if_valid", 32'(o_if_valid), 32'd0);
    check("rst_iw_out",   o_iw_out, 32'd0);
    check("rst_pc_out",   o_pc_out, 32'd0);
    check("rst_err",      32'(o_misalign_err), 32'd0);
    reset = 1'b0;
    cyc = 0; ngrants = 0;
    dlv.delete();
    #1;
  endtask

  // One clock cycle: check outputs, drive inputs, advance the memory and stream model.
  task automatic tick(input logic g, input logic r, input logic j, input logic [31:0] ja);
    if (prev_jump) check("ifv_after_jump", 32'(o_if_valid), 32'd0);
    check("misalign_err", 32'(o_misalign_err), 32'(m_err));
    if (m_err) check("req_while_err", 32'(o_mem_req), 32'd0);

    i_mem_gnt = g; i_id_ready = r; i_jump_enable = j; i_jump_addr = ja;
    if (pend.size() > 0 && pend[0].due <= cyc && (!rand_gaps || $urandom_range(0, 3) != 0)) begin
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = pend[0].data;
      void'(pend.pop_front());
    end else begin
      i_mem_rvalid = 1'b0;
      i_mem_rdata  = $urandom;
    end

    if (o_mem_req && g) begin
      check("fetch_addr", {o_mem_addr, 2'b00}, m_fetch);
      pend.push_back('{due: cyc + $urandom_range(lat_max, lat_min), data: iw_of({o_mem_addr, 2'b00})});
      check("inflight_bound", 32'(pend.size() <= DEPTH), 32'd1);
      m_fetch = m_fetch + 32'd4;
      ngrants++;
    end

    if (o_if_valid && r && !j) begin
      check("pc_out", o_pc_out, m_exp);
      check("iw_out", o_iw_out, iw_of(o_pc_out));
      dlv.push_back(o_pc_out);
      m_exp = m_exp + 32'd4;
    end

    if (j) begin
`ifdef RV32I_IF_MISALIGN_CHECK_EN
      m_err = (ja[1:0] != 2'b00);
`endif
      m_fetch = ja & 32'hFFFF_FFFC;
      m_exp   = ja & 32'hFFFF_FFFC;
    end
    prev_jump = j;

    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    // 1: streaming, latency 1, one instruction per cycle from cycle 2.
    lat_min = 1; lat_max = 1; rand_gaps = 0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      check("t1_if_valid", 32'(o_if_valid), 32'(c >= 2));
      if (c >= 2) check("t1_pc", o_pc_out, 32'(4 * (c - 2)));
      tick(1'b1, 1'b1, 1'b0, 32'h0);
    end

    // 2: ID stalled, queue fills, exactly DEPTH grants, head held at pc 0.
    do_reset();
    for (int c = 0; c < 20; c++) tick(1'b1, 1'b0, 1'b0, 32'h0);
    check("t2_grants",   32'(ngrants), 32'(DEPTH));
    check("t2_mem_req",  32'(o_mem_req), 32'd0);
    check("t2_if_valid", 32'(o_if_valid), 32'd1);
    check("t2_head_pc",  o_pc_out, 32'h0);
    check("t2_head_iw",  o_iw_out, iw_of(32'h0));

    // 3: latency 3, three fetches in flight, redirect to 0x100.
    lat_min = 3; lat_max = 3;
    do_reset();
    for (int c = 0; c < 3; c++) tick(1'b1, 1'b1, 1'b0, 32'h0);
    check("t3_req_before", 32'(o_mem_req), 32'd1);
    check("t3_ifv_before", 32'(o_if_valid), 32'd0);
    tick(1'b1, 1'b1, 1'b1, 32'h100);
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    check("t3_ifv_2nd_cycle", 32'(o_if_valid), 32'd0);
    for (int c = 0; c < 12; c++) tick(1'b1, 1'b1, 1'b0, 32'h0);
    check("t3_first_pc", first_dlv(), 32'h100);

    // 4: back-to-back redirects, the second one wins.
    lat_min = 2; lat_max = 2;
    do_reset();
    for (int c = 0; c < 4; c++) tick(1'b1, 1'b1, 1'b0, 32'h0);
    dlv.delete();
    tick(1'b1, 1'b1, 1'b1, 32'h40);
    tick(1'b1, 1'b1, 1'b1, 32'h80);
    for (int c = 0; c < 10; c++) tick(1'b1, 1'b1, 1'b0, 32'h0);
    check("t4_first_pc", first_dlv(), 32'h80);

    // 5: PC wraps from the top of the address space to zero.
    lat_min = 1; lat_max = 1;
    do_reset();
    tick(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    for (int c = 0; c < 10; c++) tick(1'b1, 1'b1, 1'b0, 32'h0);
    check("t5_pc0", first_dlv(), 32'hFFFF_FFF8);
    check("t5_pc1", (dlv.size() > 1) ? dlv[1] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    check("t5_pc2", (dlv.size() > 2) ? dlv[2] : 32'hDEAD_BEEF, 32'h0);

    // 6: misaligned redirect.
    do_reset();
    for (int c = 0; c < 3; c++) tick(1'b1, 1'b1, 1'b0, 32'h0);
    dlv.delete();
    tick(1'b1, 1'b1, 1'b1, 32'h102);
    for (int c = 0; c < 8; c++) tick(1'b1, 1'b1, 1'b0, 32'h0);
`ifdef RV32I_IF_MISALIGN_CHECK_EN
    check("t6_err_set",  32'(o_misalign_err), 32'd1);
    check("t6_no_req",   32'(o_mem_req), 32'd0);
    check("t6_no_words", 32'(dlv.size()), 32'd0);
    tick(1'b1, 1'b1, 1'b1, 32'h200);
    for (int c = 0; c < 8; c++) tick(1'b1, 1'b1, 1'b0, 32'h0);
    check("t6_err_clr",  32'(o_misalign_err), 32'd0);
    check("t6_first_pc", first_dlv(), 32'h200);
`else
    check("t6_err_tied", 32'(o_misalign_err), 32'd0);
    check("t6_first_pc", first_dlv(), 32'h100);
`endif

    // Randomized: grants, latency, response gaps, ID stalls and redirects.
    lat_min = 1; lat_max = 4; rand_gaps = 1;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      logic [31:0] ja;
      ja = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      if ($urandom_range(0, 7) == 0) ja[1] = 1'b1;
      tick(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 24) == 0), ja);
    end
    check("rand_progress", 32'(dlv.size() > 50), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
